// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard controller: owns the fetch PC and IF/ID register, applies
// redirect/stall priority, drives the ID/EX bubble and keeps hazard statistics.
module pipe_hazard_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      inst_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_inst,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CONSEC_W = 4;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_HOLD  = 2'b01,
    HZ_FLUSH = 2'b10
  } hz_state_e;

  hz_state_e             state_q, state_d;
  if_id_t                if_id_q, if_id_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic                  err_q, err_d;
  logic                  take_redirect;
  logic                  take_stall;

  // A redirect squashes any simultaneous stall request.
  assign take_redirect = redirect_valid;
  assign take_stall    = stall & ~redirect_valid;

  // Next-state and datapath selection; defaults describe a normal advance.
  always_comb begin
    state_d     = HZ_RUN;
    pc_d        = pc_q + PC_STEP;
    if_id_d     = '{pc: pc_q, inst: inst_in, valid: 1'b1};
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consec_d    = '0;
    err_d       = err_q;

    if (take_redirect) begin
      state_d = HZ_FLUSH;
      pc_d    = redirect_pc;
      if_id_d = '{pc: '0, inst: NOP_INST, valid: 1'b0};
      if (flush_cnt_q != '1) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else if (take_stall) begin
      state_d = HZ_HOLD;
      pc_d    = pc_q;
      if_id_d = if_id_q;
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      consec_d = (consec_q == '1) ? consec_q : consec_q + CONSEC_W'(1);
      // Watchdog trips on the edge where the run length reaches the limit.
      if (XLEN'(consec_q) + XLEN'(1) >= XLEN'(MAX_STALL)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      pc_q        <= RESET_PC;
      if_id_q     <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      consec_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      consec_q    <= consec_d;
      err_q       <= err_d;
    end
  end

  // Bubble kills the instruction leaving ID this cycle; masked during reset.
  assign id_ex_bubble = ~rst & (stall | redirect_valid);

  assign pc_out      = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_inst  = if_id_q.inst;
  assign if_id_valid = if_id_q.valid;
  assign hz_state    = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign stall_err   = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// hazard traffic compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_STALL = 2;
  localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst, stall, redirect_valid;
  logic [31:0]      redirect_pc, inst_in;
  logic [31:0]      pc_out, if_id_pc, if_id_inst;
  logic             if_id_valid, id_ex_bubble, stall_err;
  logic [1:0]       hz_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_in       (inst_in),
    .pc_out        (pc_out),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid),
    .id_ex_bubble  (id_ex_bubble),
    .hz_state      (hz_state),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .stall_err     (stall_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  assign inst_in = inst_of(pc_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, unbounded stall run length.
  bit          chk_en = 0;
  logic [31:0] m_pc, m_if_pc, m_if_inst;
  logic        m_if_valid, m_err;
  int          m_state, m_scnt, m_fcnt, m_run;

  always @(posedge clk) begin
    if (rst) begin
      chk_en     <= 1;
      m_pc       <= 32'h0;
      m_if_pc    <= 32'h0;
      m_if_inst  <= NOP;
      m_if_valid <= 0;
      m_state    <= 0;
      m_scnt     <= 0;
      m_fcnt     <= 0;
      m_run      <= 0;
      m_err      <= 0;
    end else if (redirect_valid) begin
      m_pc       <= redirect_pc;
      m_if_pc    <= 32'h0;
      m_if_inst  <= NOP;
      m_if_valid <= 0;
      m_state    <= 2;
      m_fcnt     <= (m_fcnt + 1 > int'(CNT_MAX)) ? int'(CNT_MAX) : m_fcnt + 1;
      m_run      <= 0;
    end else if (stall) begin
      m_state <= 1;
      m_scnt  <= (m_scnt + 1 > int'(CNT_MAX)) ? int'(CNT_MAX) : m_scnt + 1;
      m_run   <= m_run + 1;
      if (m_run + 1 >= int'(MAX_STALL)) m_err <= 1;
    end else begin
      m_if_pc    <= m_pc;
      m_if_inst  <= inst_of(m_pc);
      m_if_valid <= 1;
      m_pc       <= m_pc + 32'd4;
      m_state    <= 0;
      m_run      <= 0;
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out",       pc_out,              m_pc);
      chk("if_id_pc",     if_id_pc,            m_if_pc);
      chk("if_id_inst",   if_id_inst,          m_if_inst);
      chk("if_id_valid",  32'(if_id_valid),    32'(m_if_valid));
      chk("hz_state",     32'(hz_state),       32'(m_state));
      chk("stall_cnt",    32'(stall_cnt),      32'(m_scnt));
      chk("flush_cnt",    32'(flush_cnt),      32'(m_fcnt));
      chk("stall_err",    32'(stall_err),      32'(m_err));
      chk("id_ex_bubble", 32'(id_ex_bubble),   32'(!rst && (stall || redirect_valid)));
    end
  end

  // One cycle: drive inputs, optionally pin the combinational bubble, pass the edge.
  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                     input bit chk_b = 0, input logic eb = 1'b0);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    #1;
    if (chk_b) chk("bubble_lit", 32'(id_ex_bubble), 32'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc",    pc_out,            32'h0);
    chk("rst_ifpc",  if_id_pc,          32'h0);
    chk("rst_inst",  if_id_inst,        NOP);
    chk("rst_valid", 32'(if_id_valid),  32'h0);
    chk("rst_state", 32'(hz_state),     32'h0);
    chk("rst_scnt",  32'(stall_cnt),    32'h0);
    chk("rst_fcnt",  32'(flush_cnt),    32'h0);
    chk("rst_err",   32'(stall_err),    32'h0);
  endtask

  initial begin
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 32'h0);
    chk_reset_vals();

    // Sequential fetch from reset.
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0, 32'h0);
      chk("seq_pc",   pc_out,   32'(4 * i));
      chk("seq_ifpc", if_id_pc, 32'(4 * (i - 1)));
    end
    chk("seq_valid", 32'(if_id_valid), 32'h1);
    chk("seq_inst",  if_id_inst, 32'h000C_FFF3);

    // Single-cycle stall at 0x10.
    cyc(0, 1, 0, 32'h0, 1, 1'b1);
    chk("stall_pc",    pc_out,          32'h10);
    chk("stall_state", 32'(hz_state),   32'h1);
    chk("stall_cnt1",  32'(stall_cnt),  32'h1);
    chk("stall_err0",  32'(stall_err),  32'h0);
    cyc(0, 0, 0, 32'h0);
    chk("resume_pc",    pc_out,         32'h14);
    chk("resume_state", 32'(hz_state),  32'h0);
    chk("resume_ifpc",  if_id_pc,       32'h10);

    // Redirect at 0x20.
    repeat (3) cyc(0, 0, 0, 32'h0);
    chk("pre_redir_pc", pc_out, 32'h20);
    cyc(0, 0, 1, 32'h100, 1, 1'b1);
    chk("redir_pc",    pc_out,          32'h100);
    chk("redir_inst",  if_id_inst,      NOP);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    chk("redir_state", 32'(hz_state),   32'h2);
    chk("redir_fcnt",  32'(flush_cnt),  32'h1);
    cyc(0, 0, 0, 32'h0);
    chk("post_redir_valid", 32'(if_id_valid), 32'h1);
    chk("post_redir_ifpc",  if_id_pc,   32'h100);
    chk("post_redir_state", 32'(hz_state), 32'h0);

    // Stall and redirect together: redirect wins.
    cyc(0, 1, 1, 32'h200, 1, 1'b1);
    chk("both_pc",   pc_out,         32'h200);
    chk("both_scnt", 32'(stall_cnt), 32'h1);
    chk("both_fcnt", 32'(flush_cnt), 32'h2);

    // Watchdog: two consecutive stalls.
    cyc(0, 1, 0, 32'h0);
    chk("wd_err_first", 32'(stall_err), 32'h0);
    cyc(0, 1, 0, 32'h0);
    chk("wd_err_second", 32'(stall_err), 32'h1);
    chk("wd_scnt",       32'(stall_cnt), 32'h3);
    cyc(0, 0, 0, 32'h0);
    chk("wd_sticky", 32'(stall_err), 32'h1);

    // PC wrap.
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);
    chk("wrap_pc",   pc_out,   32'h0);
    chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

    cyc(1, 0, 0, 32'h0);
    chk("wd_clear", 32'(stall_err), 32'h0);

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 32'h0);
      cyc(0, 0, 0, 32'h0);
    end
    chk("scnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
    chk("scnt_err", 32'(stall_err), 32'h0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 32'(i * 16));
    chk("fcnt_sat", 32'(flush_cnt), 32'(CNT_MAX));

    // Reset mid-stall.
    cyc(0, 1, 0, 32'h0);
    cyc(1, 1, 0, 32'h0, 1, 1'b0);
    chk_reset_vals();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, rv;
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(99) < 35);
      rv = ($urandom_range(99) < 12);
      cyc(r, s, rv, $urandom() & 32'hFFFF_FFFC);
    end

    cyc(0, 0, 0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
